priority_req_latch: RTL

- Registered request front-end for the 8-to-3 priority encode path.
- Captures sporadic request pulses into a pending register and selects the highest-index pending request.
- Offers that index on a valid/ready handshake and clears the pending bit once the index is consumed.
- Placed directly upstream of consumers that need a stable, held priority index instead of a raw combinational code.

---
 rtl/priority_pkg.sv | 12 +
 rtl/pri_enc_n.sv | 23 ++
 rtl/priority_req_latch.sv | 116 +++++++++++
 3 files changed

// File: rtl/priority_pkg.sv
// Shared types and defaults for the registered priority request front-end.
package priority_pkg;

    localparam int PRI_N_REQ = 8;
    localparam int PRI_IDX_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } pri_state_e;

endpackage

// File: rtl/pri_enc_n.sv
// Combinational highest-index encoder with a nonzero flag.
module pri_enc_n
    import priority_pkg::*;
#(
    parameter int N_REQ = PRI_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/priority_req_latch.sv
// Pending request register with a held highest-index offer on a valid/ready port.
// Build option PRIORITY_REQ_EDGE_EN: set pending bits on rising request edges instead of levels.
module priority_req_latch
    import priority_pkg::*;
#(
    parameter int N_REQ = PRI_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] clr,
    input  logic             out_ready,
    input  logic             ovf_clr,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] pend,
    output logic             any_pend,
    output logic             overflow,
    output logic             dbg_state_o
);

    // Handshake: an index transfers on any rising edge where out_valid and
    // out_ready are both high; out_valid and out_idx stay stable until then.

    logic [N_REQ-1:0] set;
    logic [N_REQ-1:0] acc;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic             any_pend_q;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    pri_state_e       state_q, state_d;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;

`ifdef PRIORITY_REQ_EDGE_EN
    logic [N_REQ-1:0] req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_q <= '0;
        else     req_q <= req;
    end

    assign set = req & ~req_q;
`else
    assign set = req;
`endif

    pri_enc_n #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_enc (
        .vec_i   (pend_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    assign acc = (out_valid_q && out_ready) ? (N_REQ'(1) << out_idx_q) : '0;

    // clr beats set, set beats acceptance of the same bit.
    assign pend_d     = ((pend_q & ~acc) | set) & ~clr;
    assign overflow_d = (|(set & pend_q & ~acc & ~clr)) | (overflow_q & ~ovf_clr);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (enc_valid) begin
                    out_idx_d   = enc_idx;
                    out_valid_d = 1'b1;
                    state_d     = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            any_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            state_q     <= ST_IDLE;
        end else begin
            pend_q      <= pend_d;
            any_pend_q  <= |pend_q;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            state_q     <= state_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pend        = pend_q;
    assign any_pend    = any_pend_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = logic'(state_q);

endmodule
